// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types and command constants
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_TX_IDLE,
    PS2_TX_INHIBIT,
    PS2_TX_REQ,
    PS2_TX_SHIFT,
    PS2_TX_ACK,
    PS2_TX_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, debounce and fall detector
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic line_in,
  output logic filtered,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] stable_cnt;

  // two-flop synchroniser; idle bus level is high
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], line_in};
  end

  // filtered level flips after FILTER_LEN consecutive differing samples; fall marks 1->0
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      filtered   <= 1'b1;
      stable_cnt <= '0;
      fall       <= 1'b0;
    end else if (sync[1] == filtered) begin
      stable_cnt <= '0;
      fall       <= 1'b0;
    end else if (stable_cnt == CNT_LAST) begin
      filtered   <= sync[1];
      stable_cnt <= '0;
      fall       <= ~sync[1];
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
      fall       <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state;
  logic [CNT_W-1:0] cnt;          // inhibit length, then cycles since clock release
  logic [9:0]       shreg;        // {stop, parity, data}, shifted out LSB first
  logic [3:0]       bit_cnt;
  logic             clock_filt;
  logic             clock_fall;
  logic             data_filt;
  logic             data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clock_filter (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .line_in  (ps2_clock_in),
    .filtered (clock_filt),
    .fall     (clock_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .line_in  (ps2_data_in),
    .filtered (data_filt),
    .fall     (data_fall_unused)
  );

  // transfer sequencer: inhibit, request-to-send, bit shifting on device falls, ack, idle wait
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PS2_TX_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      tx_ready     <= 1'b1;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      tx_ack_ok    <= 1'b0;
      tx_error     <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        PS2_TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg        <= {1'b1, ps2_odd_parity(tx_data), tx_data};
            tx_ack_ok    <= 1'b0;
            tx_ready     <= 1'b0;
            busy         <= 1'b1;
            ps2_clock_oe <= 1'b1;
            cnt          <= '0;
            state        <= PS2_TX_INHIBIT;
          end else begin
            // held low for the cycle a transfer ends so a same-cycle request is not taken
            tx_ready <= 1'b1;
          end
        end
        PS2_TX_INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= PS2_TX_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PS2_TX_REQ: begin
          ps2_clock_oe <= 1'b0;
          cnt          <= '0;
          bit_cnt      <= '0;
          state        <= PS2_TX_SHIFT;
        end
        PS2_TX_SHIFT, PS2_TX_ACK, PS2_TX_WAIT_IDLE: begin
          if (cnt == TIMEOUT_LAST) begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_ack_ok    <= 1'b0;
            tx_error     <= 1'b1;
            busy         <= 1'b0;
            state        <= PS2_TX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == PS2_TX_SHIFT && clock_fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b1, shreg[9:1]};
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= PS2_TX_ACK;
            end else if (state == PS2_TX_ACK && clock_fall) begin
              tx_ack_ok <= ~data_filt;
              state     <= PS2_TX_WAIT_IDLE;
            end else if (state == PS2_TX_WAIT_IDLE && clock_filt && data_filt) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              state   <= PS2_TX_IDLE;
            end
          end
        end
        default: state <= PS2_TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 500;
  localparam int TIMEOUT = 3000;
  localparam int FILT    = 8;
  localparam int HALF    = 40;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error;
  logic       ps2_clock_in, ps2_data_in, ps2_clock_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low, glitch_low;

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses = 0;
  int err_pulses  = 0;

  // open-drain bus: any agent pulling low wins, otherwise the pull-up holds it high
  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low | glitch_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FILTER_LEN     (FILT)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .tx_done      (tx_done),
    .tx_ack_ok    (tx_ack_ok),
    .tx_error     (tx_error),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (tx_done)  done_pulses++;
    if (tx_error) err_pulses++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // line order as seen by the device: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic do_accept(input logic [7:0] b);
    @(negedge clk_in);
    tx_data  = b;
    tx_valid = 1'b1;
    chk("ready_at_accept", 32'(tx_ready), 32'd1);
    @(negedge clk_in);
    tx_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic check_inhibit();
    int n;
    n = 0;
    while (ps2_clock_oe && !ps2_data_oe && n < INHIBIT + 50) begin
      n++;
      @(negedge clk_in);
    end
    chk("inhibit_len", 32'(n), 32'(INHIBIT));
    chk("req_both_low", 32'({ps2_clock_oe, ps2_data_oe}), 32'b11);
  endtask

  task automatic dev_frame(input bit do_ack, input int glitch_at, input int poke_at,
                           input int abort_at, output logic [10:0] frame, output bit ok);
    int k;
    ok = 1'b0;
    frame = '0;
    k = 0;
    while (ps2_clock_oe && k < 20) begin
      k++;
      @(negedge clk_in);
    end
    if (ps2_clock_oe) return;
    repeat (HALF) @(negedge clk_in);
    frame[0] = ps2_data_in;
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_in);
      frame[i+1] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (i == abort_at) begin
        ok = 1'b1;
        return;
      end
      if (i == glitch_at) begin
        repeat (15) @(negedge clk_in);
        glitch_low = 1'b1;
        repeat (3) @(negedge clk_in);
        glitch_low = 1'b0;
        repeat (HALF - 18) @(negedge clk_in);
      end else if (i == poke_at) begin
        repeat (5) @(negedge clk_in);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        chk("ready_low_mid_shift", 32'(tx_ready), 32'd0);
        @(negedge clk_in);
        tx_valid = 1'b0;
        repeat (HALF - 6) @(negedge clk_in);
      end else begin
        repeat (HALF) @(negedge clk_in);
      end
    end
    dev_data_low = do_ack;
    repeat (15) @(negedge clk_in);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk_in);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_done(input bit exp_ack);
    int n;
    n = 0;
    while (!tx_done && n < 300) begin
      n++;
      @(negedge clk_in);
    end
    chk("done_seen", 32'(tx_done), 32'd1);
    chk("ack_ok", 32'(tx_ack_ok), 32'(exp_ack));
    chk("ready_low_on_done", 32'(tx_ready), 32'd0);
    chk("no_error_on_done", 32'(tx_error), 32'd0);
    @(negedge clk_in);
    chk("ready_after_done", 32'(tx_ready), 32'd1);
    chk("ack_ok_held", 32'(tx_ack_ok), 32'(exp_ack));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit do_ack, input int glitch_at,
                            input int poke_at, input int abort_at, output logic [10:0] frame);
    bit ok;
    int d0;
    d0 = done_pulses;
    do_accept(b);
    check_inhibit();
    dev_frame(do_ack, glitch_at, poke_at, abort_at, frame, ok);
    chk("dev_saw_request", 32'(ok), 32'd1);
    if (abort_at < 0) begin
      chk("frame", 32'(frame), 32'(expected_frame(b)));
      wait_done(do_ack);
      chk("one_done_pulse", 32'(done_pulses - d0), 32'd1);
    end
  endtask

  initial begin
    logic [10:0] frame;
    logic [10:0] exp_frame;
    logic [7:0]  rb;
    bit          rack;
    int          n, d0;

    reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    glitch_low = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("rst_ready_busy", 32'({tx_ready, busy}), 32'b10);
    chk("rst_pulses_ack", 32'({tx_done, tx_ack_ok, tx_error}), 32'b000);
    chk("rst_oe", 32'({ps2_clock_oe, ps2_data_oe}), 32'b00);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // set-LEDs command with device ACK
    send_frame(PS2_CMD_SET_LEDS, 1'b1, -1, -1, -1, frame);
    // parity boundaries
    send_frame(8'h01, 1'b1, -1, -1, -1, frame);
    send_frame(PS2_CMD_RESET, 1'b1, -1, -1, -1, frame);
    // missing ACK
    send_frame(8'h3C, 1'b0, -1, -1, -1, frame);
    // request while busy is dropped
    send_frame(8'hA7, 1'b1, -1, 4, -1, frame);
    // short clock glitch in mid-frame
    send_frame(8'h96, 1'b1, 2, -1, -1, frame);

    // device never clocks
    d0 = done_pulses;
    do_accept(PS2_CMD_RESET);
    check_inhibit();
    @(negedge clk_in);
    n = 0;
    while (!tx_error && n < TIMEOUT + 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_oe", 32'({ps2_clock_oe, ps2_data_oe}), 32'b00);
    chk("timeout_ready_low", 32'(tx_ready), 32'd0);
    @(negedge clk_in);
    chk("timeout_ready_next", 32'(tx_ready), 32'd1);
    chk("timeout_ack_ok", 32'(tx_ack_ok), 32'd0);
    chk("timeout_no_done", 32'(done_pulses - d0), 32'd0);

    // reset in the middle of a frame
    send_frame(8'hE0, 1'b1, -1, -1, 3, frame);
    exp_frame = expected_frame(8'hE0);
    chk("abort_prefix", 32'(frame[4:0]), 32'(exp_frame[4:0]));
    repeat (5) @(negedge clk_in);
    chk("abort_data_driven", 32'(ps2_data_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_oe", 32'({ps2_clock_oe, ps2_data_oe}), 32'b00);
    chk("async_reset_ready", 32'({tx_ready, busy}), 32'b10);
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);
    send_frame(PS2_CMD_ECHO, 1'b1, -1, -1, -1, frame);

    // random bytes and ACK behaviour
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      send_frame(rb, rack, -1, -1, -1, frame);
    end

    chk("total_error_pulses", 32'(err_pulses), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
